// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule expander (16-word sliding window)
//
// Purpose:
//   Accepts one 512-bit block and emits the NUM_ROUNDS-word schedule W[0..NUM_ROUNDS-1],
//   one word per accepted beat, using a 16-word sliding window.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    synchronous reset, active low
//   enable     in   1    global advance; low freezes all state
//   blk_valid  in   1    input block valid
//   blk_ready  out  1    block accepted when blk_valid & blk_ready
//   blk_data   in   512  W[0] in bits [511:480], W[15] in bits [31:0]
//   w_valid    out  1    schedule word valid
//   w_ready    in   1    consumer accepts w_data
//   w_data     out  32   current schedule word W[t]
//   w_last     out  1    high with w_valid on the final word
//   busy       out  1    high while a block is being expanded
//   w_idx      out  6    current index t (only with SCHED_IDX_OUT_EN defined)
//
// Configuration macro: SCHED_IDX_OUT_EN adds the w_idx output.

module sha256_msg_schedule #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_ROUNDS = 64,
  parameter int S0_R1      = 7,
  parameter int S0_R2      = 18,
  parameter int S0_SH      = 3,
  parameter int S1_R1      = 17,
  parameter int S1_R2      = 19,
  parameter int S1_SH      = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [16*WORD_WIDTH-1:0] blk_data,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [WORD_WIDTH-1:0]   w_data,
  output logic                    w_last,
  output logic                    busy
`ifdef SCHED_IDX_OUT_EN
  ,
  output logic [5:0]              w_idx
`endif
);

  localparam int T_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [T_W-1:0]        r_t;
  logic [T_W-1:0]        w_t_nxt;
  logic [WORD_WIDTH-1:0] r_win [16];

  logic                  w_blk_acc;
  logic                  w_word_acc;
  logic                  w_t_is_last;
  logic [WORD_WIDTH-1:0] w_new_word;

  function automatic logic [WORD_WIDTH-1:0] rotr(input logic [WORD_WIDTH-1:0] x, input int n);
    return (x >> n) | (x << (WORD_WIDTH - n));
  endfunction

  function automatic logic [WORD_WIDTH-1:0] sig0(input logic [WORD_WIDTH-1:0] x);
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [WORD_WIDTH-1:0] sig1(input logic [WORD_WIDTH-1:0] x);
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction

  assign w_t_is_last = (r_t == T_W'(NUM_ROUNDS - 1));

  // Window slot 15 after the shift holds W[t+16], which depends on W[t+14],
  // W[t+9], W[t+1] and W[t] -- slots 14, 9, 1 and 0 of the current window.
  assign w_new_word = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

  assign w_data = r_win[0];

  // Outputs are gated with rst_n so the reset cycle itself shows an idle
  // interface and no handshake can complete against a reset edge.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    blk_ready   = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    w_blk_acc   = 1'b0;
    w_word_acc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        blk_ready = enable & rst_n;
        w_blk_acc = blk_ready & blk_valid;
        if (w_blk_acc) begin
          w_state_nxt = S_RUN;
          w_t_nxt     = '0;
        end
      end
      S_RUN: begin
        busy       = rst_n;
        w_valid    = enable & rst_n;
        w_last     = w_valid & w_t_is_last;
        w_word_acc = w_valid & w_ready;
        if (w_word_acc) begin
          if (w_t_is_last) begin
            w_state_nxt = S_IDLE;
            w_t_nxt     = '0;
          end else begin
            w_t_nxt = r_t + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_t_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_blk_acc) begin
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= blk_data[(16*WORD_WIDTH-1)-WORD_WIDTH*i -: WORD_WIDTH];
      end
    end else if (w_word_acc) begin
      for (int i = 0; i < 15; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[15] <= w_new_word;
    end
  end

`ifdef SCHED_IDX_OUT_EN
  assign w_idx = (r_state == S_RUN && rst_n) ? 6'(r_t) : 6'd0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - self-checking bench for sha256_msg_schedule

module tb_sha256_msg_schedule;

  localparam int NR = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic         w_last;
  logic         busy;
`ifdef SCHED_IDX_OUT_EN
  logic [5:0]   w_idx;
`endif

  always #5 clk = ~clk;

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_last    (w_last),
    .busy      (busy)
`ifdef SCHED_IDX_OUT_EN
    ,
    .w_idx     (w_idx)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: textbook schedule recurrence over a full 64-entry array.
  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] sched_word(input logic [511:0] b, input int t);
    logic [31:0] w [NR];
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < NR; i++) w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
    return w[t];
  endfunction

  // Monitor / scoreboard state
  int          cyc = 0;
  int          beat = 0;
  int          blocks_done = 0;
  int          accepts = 0;
  int          last_done_cyc = -100;
  bit          active = 0;
  bit          gap_chk = 0;
  bit          rand_rdy = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic [31:0] exp_w [NR];

  // Inputs change at posedge+1, so values seen here are exactly those the
  // next rising edge will act on.
  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b0) begin
      active     = 0;
      beat       = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_data_hold", w_data, prev_data);
        if (enable) chk("no_retract", w_valid, 1);
      end
      if (!enable) begin
        chk("frozen_w_valid", w_valid, 0);
        chk("frozen_blk_ready", blk_ready, 0);
      end
      if (busy) chk("blk_ready_in_run", blk_ready, 0);
      chk("busy_vs_model", busy, active);
      if (!w_valid) chk("last_without_valid", w_last, 0);
      if (w_valid && w_ready) begin
        chk($sformatf("w_data[%0d]", beat), w_data, exp_w[beat]);
        chk($sformatf("w_last[%0d]", beat), w_last, (beat == NR-1));
`ifdef SCHED_IDX_OUT_EN
        chk($sformatf("w_idx[%0d]", beat), w_idx, beat);
`endif
        beat++;
        if (beat == NR) begin
          active        = 0;
          beat          = 0;
          blocks_done++;
          last_done_cyc = cyc;
        end
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      if (blk_valid && blk_ready) begin
        for (int j = 0; j < NR; j++) exp_w[j] = sched_word(blk_data, j);
        if (gap_chk) chk("b2b_gap_cycles", cyc - last_done_cyc, 1);
        active = 1;
        beat   = 0;
        accepts++;
      end
    end
  end

  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      w_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [511:0] b);
    int a0;
    int n;
    a0        = accepts;
    n         = 0;
    blk_data  = b;
    blk_valid = 1'b1;
    while (accepts == a0 && n < 200) begin
      step();
      n++;
    end
    blk_valid = 1'b0;
    chk("accept_timeout", accepts, a0 + 1);
  endtask

  task automatic wait_blocks(input int target);
    int n;
    n = 0;
    while (blocks_done < target && n < 5000) begin
      step();
      n++;
    end
    chk("blocks_timeout", blocks_done, target);
  endtask

  task automatic wait_beat(input int target);
    int n;
    n = 0;
    while (beat < target && n < 2000) begin
      step();
      n++;
    end
    chk("beat_timeout", beat, target);
  endtask

  logic [511:0] abc_blk;
  int           a0;
  int           n;

  initial begin
    abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
    rst_n     = 1'b0;
    enable    = 1'b1;
    blk_valid = 1'b0;
    blk_data  = '0;

    // Reset state, sampled during and after reset
    step();
    @(negedge clk);
    chk("rst_blk_ready", blk_ready, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_w_data", w_data, 0);
    chk("post_rst_w_last", w_last, 0);
    chk("post_rst_blk_ready", blk_ready, 1);
    step();

    // Pin the reference model with hand-known values
    chk("model_W16", sched_word(abc_blk, 16), 32'h61626380);
    chk("model_W17", sched_word(abc_blk, 17), 32'h000F0000);
    chk("model_W18", sched_word(abc_blk, 18), 32'h7DA86405);
    chk("model_W15", sched_word(abc_blk, 15), 32'h00000018);

    // 1: abc block, w_ready held high
    rand_rdy = 0;
    send_block(abc_blk);
    wait_blocks(1);

    // 2: same block, random backpressure
    rand_rdy = 1;
    send_block(abc_blk);
    wait_blocks(2);

    // enable low in IDLE blocks acceptance
    step();
    enable    = 1'b0;
    blk_valid = 1'b1;
    blk_data  = abc_blk;
    a0        = accepts;
    repeat (3) step();
    chk("no_accept_when_disabled", accepts, a0);
    blk_valid = 1'b0;
    enable    = 1'b1;

    // 3: enable gap of 5 cycles at t=20
    rand_rdy = 0;
    send_block(abc_blk);
    wait_beat(20);
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    wait_blocks(3);

    // 4: reset mid-block at t=30, then a fresh block
    rand_rdy = 1;
    send_block(rand_block());
    wait_beat(30);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_w_valid", w_valid, 0);
    chk("midrst_blk_ready", blk_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_w_data", w_data, 0);
    step();
    n = blocks_done;
    send_block(abc_blk);
    wait_blocks(n + 1);

    // 5: two blocks back-to-back with blk_valid held high
    rand_rdy  = 1;
    n         = blocks_done;
    a0        = accepts;
    blk_data  = rand_block();
    blk_valid = 1'b1;
    while (accepts == a0 && cyc < 90000) step();
    blk_data = rand_block();
    gap_chk  = 1;
    while (accepts == a0 + 1 && cyc < 90000) step();
    blk_valid = 1'b0;
    gap_chk   = 0;
    chk("b2b_accepts", accepts, a0 + 2);
    wait_blocks(n + 2);

    // Extra random blocks with random backpressure and enable dips
    for (int k = 0; k < 3; k++) begin
      n = blocks_done;
      send_block(rand_block());
      for (int c = 0; c < 40; c++) begin
        enable = ($urandom_range(0, 7) != 0);
        step();
      end
      enable = 1'b1;
      wait_blocks(n + 1);
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
